// File: rtl/mux_n_1_scan_pkg.sv
// rtl/mux_n_1_scan_pkg.sv - shared state encodings and width helper for scanning muxes
package mux_n_1_scan_pkg;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } scan_state_t;

    // Constant-foldable ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_n_1_scan_dwell_cnt.sv
// rtl/mux_n_1_scan_dwell_cnt.sv - dwell counter, pulses wrap on its last cycle of each dwell
module dwell_cnt
    import mux_n_1_scan_pkg::*;
#(
    parameter int DWELL = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic wrap
);

    localparam int DW = clog2(DWELL + 1);
    localparam logic [DW-1:0] LAST = DW'(DWELL - 1);

    logic [DW-1:0] dcnt;

    assign wrap = enable && !clear && (dcnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt <= '0;
        end else if (clear || wrap) begin
            dcnt <= '0;
        end else if (enable) begin
            dcnt <= dcnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_n_1_scan.sv
// rtl/mux_n_1_scan.sv - registered N:1 mux with latched manual select or round-robin scan
module mux_n_1_scan
    import mux_n_1_scan_pkg::*;
#(
    parameter int CH    = 4,
    parameter int WIDTH = 8,
    parameter int DWELL = 10,
    localparam int CW   = clog2(CH)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [CH*WIDTH-1:0]   in_data,
    input  logic [CW-1:0]         sel,
    input  logic                  sel_load,
    input  logic                  scan_en,
    output logic [WIDTH-1:0]      out,
    output logic [CW-1:0]         out_ch,
    output logic                  out_valid,
    output logic                  ch_switch,
    output logic                  sel_err
);

    scan_state_t      state;
    scan_state_t      state_next;
    logic [CW-1:0]    cur_ch;
    logic [CW-1:0]    cur_ch_next;
    logic             sel_err_next;
    logic             scan_active;
    logic             wrap;
    logic             valid_q;
    logic [WIDTH-1:0] sel_data;

    // Counting only while scan_en is still high, so the exit cycle never advances the channel.
    assign scan_active = (state == ST_SCAN) && scan_en;

    dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell_cnt (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .enable (scan_active),
        .clear  (!scan_active),
        .wrap   (wrap)
    );

    always_comb begin
        state_next   = scan_en ? ST_SCAN : ST_MANUAL;
        cur_ch_next  = cur_ch;
        sel_err_next = 1'b0;
        if (state == ST_MANUAL) begin
            if (sel_load) begin
                if (int'(sel) < CH) begin
                    cur_ch_next = sel;
                end else begin
                    sel_err_next = 1'b1;
                end
            end
        end else if (wrap) begin
            cur_ch_next = (cur_ch == CW'(CH - 1)) ? '0 : cur_ch + 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (cur_ch == CW'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= ST_MANUAL;
            cur_ch    <= '0;
            sel_err   <= 1'b0;
            out       <= '0;
            out_ch    <= '0;
            ch_switch <= 1'b0;
            valid_q   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            cur_ch    <= cur_ch_next;
            sel_err   <= sel_err_next;
            out       <= sel_data;
            out_ch    <= cur_ch;
            // out_ch still holds the previous cur_ch, so this flags the cycle out_ch changes.
            ch_switch <= (cur_ch != out_ch);
            valid_q   <= 1'b1;
            out_valid <= valid_q;
        end
    end

endmodule

// File: tb/tb_mux_n_1_scan.sv
// tb/tb_mux_n_1_scan.sv - directed scoreboard bench for mux_n_1_scan in three configurations
module tb_mux_n_1_scan;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // CH=4 WIDTH=8 DWELL=10
    logic [31:0] in4;
    logic [1:0]  sel4;
    logic        ld4, sc4;
    logic [7:0]  out4;
    logic [1:0]  ch4;
    logic        v4, sw4, er4;

    // CH=3 WIDTH=8 DWELL=4
    logic [23:0] in3;
    logic [1:0]  sel3;
    logic        ld3, sc3;
    logic [7:0]  out3;
    logic [1:0]  ch3;
    logic        v3, sw3, er3;

    // CH=5 WIDTH=4 DWELL=1
    logic [19:0] in1;
    logic [2:0]  sel1;
    logic        ld1, sc1;
    logic [3:0]  out1;
    logic [2:0]  ch1;
    logic        v1, sw1, er1;

    mux_n_1_scan #(.CH(4), .WIDTH(8), .DWELL(10)) dut4 (
        .sys_clk (clk), .sys_rst (rst), .in_data (in4), .sel (sel4), .sel_load (ld4),
        .scan_en (sc4), .out (out4), .out_ch (ch4), .out_valid (v4), .ch_switch (sw4),
        .sel_err (er4)
    );

    mux_n_1_scan #(.CH(3), .WIDTH(8), .DWELL(4)) dut3 (
        .sys_clk (clk), .sys_rst (rst), .in_data (in3), .sel (sel3), .sel_load (ld3),
        .scan_en (sc3), .out (out3), .out_ch (ch3), .out_valid (v3), .ch_switch (sw3),
        .sel_err (er3)
    );

    mux_n_1_scan #(.CH(5), .WIDTH(4), .DWELL(1)) dut1 (
        .sys_clk (clk), .sys_rst (rst), .in_data (in1), .sel (sel1), .sel_load (ld1),
        .scan_en (sc1), .out (out1), .out_ch (ch1), .out_valid (v1), .ch_switch (sw1),
        .sel_err (er1)
    );

    typedef struct {
        string      tag;
        int         dut;
        logic [7:0] d;
        logic [3:0] ch;
        logic       v;
        logic       sw;
        logic       er;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input int dut, input logic [7:0] d,
                        input logic [3:0] ch, input logic v, input logic sw, input logic er);
        exp_t e;
        e.tag = tag; e.dut = dut; e.d = d; e.ch = ch; e.v = v; e.sw = sw; e.er = er;
        q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        exp_t       e;
        logic [7:0] od;
        logic [3:0] oc;
        logic       ov, osw, oer;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.dut)
                4:       begin od = out4;         oc = {2'b0, ch4}; ov = v4; osw = sw4; oer = er4; end
                3:       begin od = out3;         oc = {2'b0, ch3}; ov = v3; osw = sw3; oer = er3; end
                default: begin od = {4'h0, out1}; oc = {1'b0, ch1}; ov = v1; osw = sw1; oer = er1; end
            endcase
            chk($sformatf("%s.d%0d.out", e.tag, e.dut),       od,         e.d);
            chk($sformatf("%s.d%0d.out_ch", e.tag, e.dut),    {4'h0, oc}, {4'h0, e.ch});
            chk($sformatf("%s.d%0d.valid", e.tag, e.dut),     {7'h0, ov}, {7'h0, e.v});
            chk($sformatf("%s.d%0d.ch_switch", e.tag, e.dut), {7'h0, osw}, {7'h0, e.sw});
            chk($sformatf("%s.d%0d.sel_err", e.tag, e.dut),   {7'h0, oer}, {7'h0, e.er});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [7:0] by3(input int c);
        return in3[c*8 +: 8];
    endfunction

    function automatic logic [7:0] nib1(input int c);
        return {4'h0, in1[c*4 +: 4]};
    endfunction

    initial begin
        rst = 1'b1;
        in4 = 32'hDDCCBBAA; sel4 = '0; ld4 = 1'b0; sc4 = 1'b0;
        in3 = 24'h332211;   sel3 = '0; ld3 = 1'b0; sc3 = 1'b0;
        in1 = 20'h9ABCD;    sel1 = '0; ld1 = 1'b0; sc1 = 1'b0;

        #12;
        push("reset", 4, 8'h00, 0, 0, 0, 0);
        push("reset", 3, 8'h00, 0, 0, 0, 0);
        push("reset", 1, 8'h00, 0, 0, 0, 0);
        check_all();

        rst = 1'b0;
        push("rel_e1", 4, 8'hAA, 0, 0, 0, 0);
        push("rel_e1", 3, 8'h11, 0, 0, 0, 0);
        push("rel_e1", 1, 8'h0D, 0, 0, 0, 0);
        tick();
        push("rel_e2", 4, 8'hAA, 0, 1, 0, 0);
        push("rel_e2", 3, 8'h11, 0, 1, 0, 0);
        push("rel_e2", 1, 8'h0D, 0, 1, 0, 0);
        tick();

        // manual select and same-channel reload
        sel4 = 2'd2; ld4 = 1'b1;
        push("ld_e1", 4, 8'hAA, 0, 1, 0, 0); tick();
        ld4 = 1'b0;
        push("ld_e2", 4, 8'hCC, 2, 1, 1, 0); tick();
        push("ld_hold", 4, 8'hCC, 2, 1, 0, 0); tick();
        ld4 = 1'b1;
        push("reld_e1", 4, 8'hCC, 2, 1, 0, 0); tick();
        ld4 = 1'b0;
        push("reld_e2", 4, 8'hCC, 2, 1, 0, 0); tick();
        in4 = 32'hDD5EBBAA;
        push("din", 4, 8'h5E, 2, 1, 0, 0); tick();

        // out-of-range select on CH=3
        sel3 = 2'd3; ld3 = 1'b1;
        push("bad_e1", 3, 8'h11, 0, 1, 0, 1); tick();
        ld3 = 1'b0;
        push("bad_e2", 3, 8'h11, 0, 1, 0, 0); tick();

        // DWELL=1 scan on CH=5: advances every cycle, wraps 4->0
        sc1 = 1'b1;
        push("d1_entry", 1, nib1(0), 0, 1, 0, 0); tick();
        push("d1_first", 1, nib1(0), 0, 1, 0, 0); tick();
        for (int k = 1; k <= 7; k++) begin
            push($sformatf("d1_k%0d", k), 1, nib1(k % 5), 4'(k % 5), 1, 1, 0);
            tick();
        end
        sc1 = 1'b0;

        // scan on CH=3 DWELL=4 from channel 1
        sel3 = 2'd1; ld3 = 1'b1;
        push("s_ld1", 3, 8'h11, 0, 1, 0, 0); tick();
        ld3 = 1'b0;
        push("s_ld2", 3, 8'h22, 1, 1, 1, 0); tick();
        sc3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push($sformatf("s_entry%0d", i), 3, 8'h22, 1, 1, 0, 0); tick();
        end
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) begin
                int c;
                c = (p + 2) % 3;
                ld3  = (i == 1) && (p < 2);
                sel3 = (p == 0) ? 2'd3 : 2'd1;
                push($sformatf("scan_p%0d_i%0d", p, i), 3, by3(c), 4'(c), 1, (i == 0), 0);
                tick();
            end
        end
        push("s_wrap2", 3, by3(2), 2, 1, 1, 0); tick();

        // exit mid-dwell: channel must hold
        sc3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push($sformatf("exit%0d", i), 3, by3(2), 2, 1, 0, 0); tick();
        end

        // scan_en rising together with a valid load
        sel3 = 2'd0; ld3 = 1'b1; sc3 = 1'b1;
        push("sim_e1", 3, by3(2), 2, 1, 0, 0); tick();
        ld3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push($sformatf("sim_ch0_%0d", i), 3, by3(0), 0, 1, (i == 0), 0); tick();
        end
        push("sim_ch1", 3, by3(1), 1, 1, 1, 0); tick();

        // asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        push("async_rst", 4, 8'h00, 0, 0, 0, 0);
        push("async_rst", 3, 8'h00, 0, 0, 0, 0);
        push("async_rst", 1, 8'h00, 0, 0, 0, 0);
        check_all();
        sc3 = 1'b0;
        #10;
        rst = 1'b0;
        push("post_e1", 3, 8'h11, 0, 0, 0, 0);
        push("post_e1", 4, 8'hAA, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            push($sformatf("post_man%0d", i), 3, 8'h11, 0, 1, 0, 0); tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
